// File: rtl/autoconfig_chain_pkg.sv
// Shared constants, FSM state type and size-code helper for the AUTOCONFIG responder.
package autoconfig_pkg;

    localparam logic [6:0] OFS_BASE_HI = 7'h48;
    localparam logic [6:0] OFS_BASE_LO = 7'h4A;
    localparam logic [6:0] OFS_SHUTUP  = 7'h4C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    // Lowest address bit compared by the decoder for a given er_type size code.
    function automatic logic [4:0] size_msb(input logic [2:0] size_code);
        if (size_code == 3'd0) return 5'd23;
        return 5'd15 + {2'b00, size_code};
    endfunction

endpackage

// File: rtl/autoconfig_chain_if.sv
// Bus-side signals of the AUTOCONFIG responder.
// Handshake: the master drops AS20, then DS20; the slave raises READY once the
// access is done and holds it until the master releases AS20.
interface autoconfig_chain_if;
    logic        AS20;
    logic        DS20;
    logic        RW20;
    logic [23:0] A;
    logic [3:0]  D;
    logic [3:0]  DOUT;
    logic        DOE;
    logic        ACCESS;
    logic        READY;

    modport slave (
        input  AS20, DS20, RW20, A, D,
        output DOUT, DOE, ACCESS, READY
    );

    modport master (
        output AS20, DS20, RW20, A, D,
        input  DOUT, DOE, ACCESS, READY
    );
endinterface

// File: rtl/autoconfig_chain_rom.sv
// Combinational AUTOCONFIG nibble ROM: every byte but er_type is stored inverted on the bus.
module autoconfig_rom
    import autoconfig_pkg::*;
#(
    parameter int                      NUM_BOARDS   = 2,
    parameter logic [NUM_BOARDS*8-1:0] ER_TYPE      = {8'hC1, 8'hE6},
    parameter logic [NUM_BOARDS*8-1:0] ER_PRODUCT   = {8'h72, 8'h7F},
    parameter logic [15:0]             MANUFACTURER = 16'h07DB,
    parameter logic [31:0]             SERIAL       = 32'h0
) (
    input  logic [1:0] board_i,
    input  logic [6:0] offset_i,
    output logic [3:0] nibble_o
);

    logic [7:0] rom_byte;
    logic       mapped;
    logic       invert;
    logic [3:0] raw_nibble;
    logic       unused_ofs;

    assign unused_ofs = offset_i[0];

    always_comb begin
        rom_byte = 8'h00;
        mapped   = 1'b1;
        invert   = 1'b1;
        case (offset_i[6:2])
            5'd0: begin
                rom_byte = ER_TYPE[{board_i, 3'b000} +: 8];
                invert   = 1'b0;
            end
            5'd1:    rom_byte = ER_PRODUCT[{board_i, 3'b000} +: 8];
            5'd2:    rom_byte = 8'h00;
            5'd4:    rom_byte = MANUFACTURER[15:8];
            5'd5:    rom_byte = MANUFACTURER[7:0];
            5'd6:    rom_byte = SERIAL[31:24];
            5'd7:    rom_byte = SERIAL[23:16];
            5'd8:    rom_byte = SERIAL[15:8];
            5'd9:    rom_byte = SERIAL[7:0];
            default: mapped   = 1'b0;
        endcase

        raw_nibble = offset_i[1] ? rom_byte[3:0] : rom_byte[7:4];

        if (!mapped || int'(board_i) >= NUM_BOARDS) nibble_o = 4'hF;
        else if (invert)                            nibble_o = ~raw_nibble;
        else                                        nibble_o = raw_nibble;
    end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AUTOCONFIG chain responder: synchronised strobes, per-board base
// registers assigned by the OS, and active-low per-board address decodes.
module autoconfig_chain
    import autoconfig_pkg::*;
#(
    parameter int                      NUM_BOARDS   = 2,
    parameter logic [NUM_BOARDS*8-1:0] ER_TYPE      = {8'hC1, 8'hE6},
    parameter logic [NUM_BOARDS*8-1:0] ER_PRODUCT   = {8'h72, 8'h7F},
    parameter logic [15:0]             MANUFACTURER = 16'h07DB,
    parameter logic [31:0]             SERIAL       = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    autoconfig_chain_if.slave     bus,
    output logic [NUM_BOARDS-1:0] DECODE,
    output logic [NUM_BOARDS-1:0] CONFIGURED,
    output state_e                DBG_STATE
);

    localparam logic [2:0] DONE_IDX = 3'(NUM_BOARDS);

    state_e                      state_q;
    logic                        as_s1_q, as_s2_q, as_prev_q;
    logic                        ds_s1_q, ds_s2_q, ds_prev_q;
    logic                        ready_q, doe_q;
    logic [3:0]                  dout_q;
    logic [2:0]                  cur_q, cur_d;
    logic [NUM_BOARDS-1:0]       configured_q, shutup_q;
    logic [NUM_BOARDS-1:0][7:0]  base_q;
    logic [NUM_BOARDS-1:0][3:0]  base_lo_q;
    logic [NUM_BOARDS-1:0]       decode_q, decode_d;

    logic       as_fall, as_rise, ds_fall;
    logic       done;
    logic       access_n;
    logic [6:0] offset;
    logic [3:0] rom_nibble;
    logic       unused_addr;

    assign unused_addr = ^{bus.A[15:7], bus.A[0]};

    // Synchronisers reset to the asserted level so a strobe still held low
    // across reset is not mistaken for a fresh falling edge.
    assign as_fall = as_prev_q & ~as_s2_q;
    assign as_rise = ~as_prev_q & as_s2_q;
    assign ds_fall = ds_prev_q & ~ds_s2_q;

    assign done     = (cur_q == DONE_IDX);
    assign access_n = ~((bus.A[23:16] == 8'hE8) && !done);
    assign offset   = {bus.A[6:1], 1'b0};

    assign bus.ACCESS = access_n;
    assign bus.READY  = ready_q;
    assign bus.DOE    = doe_q;
    assign bus.DOUT   = dout_q;
    assign DECODE     = decode_q;
    assign CONFIGURED = configured_q;
    assign DBG_STATE  = state_q;

    autoconfig_rom #(
        .NUM_BOARDS  (NUM_BOARDS),
        .ER_TYPE     (ER_TYPE),
        .ER_PRODUCT  (ER_PRODUCT),
        .MANUFACTURER(MANUFACTURER),
        .SERIAL      (SERIAL)
    ) u_rom (
        .board_i (cur_q[1:0]),
        .offset_i(offset),
        .nibble_o(rom_nibble)
    );

    always_comb begin
        cur_d = DONE_IDX;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (!configured_q[i] && !shutup_q[i]) cur_d = 3'(i);
        end
    end

    // Compare A[23:k] against the assigned base; base_q holds A[23:16].
    always_comb begin
        logic [4:0] k;
        logic [7:0] mask;
        logic       match;
        k        = 5'd23;
        mask     = 8'h00;
        match    = 1'b0;
        decode_d = '1;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            k = size_msb(ER_TYPE[i*8 +: 3]);
            for (int b = 0; b < 8; b++) mask[b] = (5'(16 + b) >= k);
            match       = (((bus.A[23:16] ^ base_q[i]) & mask) == 8'h00);
            decode_d[i] = ~(configured_q[i] && !shutup_q[i] && match);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            as_s1_q      <= 1'b0;
            as_s2_q      <= 1'b0;
            as_prev_q    <= 1'b0;
            ds_s1_q      <= 1'b0;
            ds_s2_q      <= 1'b0;
            ds_prev_q    <= 1'b0;
            ready_q      <= 1'b0;
            doe_q        <= 1'b0;
            dout_q       <= 4'hF;
            cur_q        <= 3'd0;
            configured_q <= '0;
            shutup_q     <= '0;
            base_q       <= '0;
            base_lo_q    <= '0;
            decode_q     <= '1;
        end else begin
            as_s1_q   <= bus.AS20;
            as_s2_q   <= as_s1_q;
            as_prev_q <= as_s2_q;
            ds_s1_q   <= bus.DS20;
            ds_s2_q   <= ds_s1_q;
            ds_prev_q <= ds_s2_q;
            decode_q  <= decode_d;

            if (as_rise) cur_q <= cur_d;

            case (state_q)
                ST_IDLE: begin
                    if (as_fall && !access_n) state_q <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (as_rise) begin
                        state_q <= ST_IDLE;
                    end else if (ds_fall) begin
                        state_q <= ST_ACK;
                        ready_q <= 1'b1;
                        doe_q   <= bus.RW20;
                        if (bus.RW20) begin
                            dout_q <= rom_nibble;
                        end else begin
                            for (int i = 0; i < NUM_BOARDS; i++) begin
                                if (cur_q == 3'(i)) begin
                                    case (offset)
                                        OFS_BASE_LO: base_lo_q[i] <= bus.D;
                                        OFS_BASE_HI: begin
                                            if (!configured_q[i] && !shutup_q[i]) begin
                                                base_q[i]       <= {bus.D, base_lo_q[i]};
                                                configured_q[i] <= 1'b1;
                                            end
                                        end
                                        OFS_SHUTUP: begin
                                            if (!configured_q[i]) shutup_q[i] <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (as_rise) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        doe_q   <= 1'b0;
                        dout_q  <= 4'hF;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
// Directed bench for autoconfig_chain with three boards: ROM reads, base
// assignment, shut-up, decode windows and strobe/reset corner cases.
module tb_autoconfig_chain;
    import autoconfig_pkg::*;

    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] decode;
    logic [NB-1:0] configured;
    state_e        dbg_state;

    int total = 0;
    int bad   = 0;

    autoconfig_chain_if bus_if ();

    autoconfig_chain #(
        .NUM_BOARDS  (NB),
        .ER_TYPE     ({8'hE6, 8'hE0, 8'hC1}),
        .ER_PRODUCT  ({8'h11, 8'h7F, 8'h72}),
        .MANUFACTURER(16'h07DB),
        .SERIAL      (32'h12345678)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .bus       (bus_if),
        .DECODE    (decode),
        .CONFIGURED(configured),
        .DBG_STATE (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [23:0] addr;
        logic [3:0]  wdata;
        logic [3:0]  exp;
    } vec_t;

    typedef struct {
        logic [23:0]   addr;
        logic [NB-1:0] exp_dec;
    } dec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cycle(input string name, input logic rw, input logic [23:0] addr,
                            input logic [3:0] wdata, output logic [3:0] dout, output logic doe);
        @(negedge clk);
        bus_if.A    = addr;
        bus_if.RW20 = rw;
        bus_if.D    = wdata;
        bus_if.AS20 = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.DS20 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus_if.READY) break;
        end
        check({name, "_ready"}, 32'(bus_if.READY), 32'd1);
        dout = bus_if.DOUT;
        doe  = bus_if.DOE;
        @(negedge clk);
        bus_if.AS20 = 1'b1;
        bus_if.DS20 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!bus_if.READY) break;
        end
        check({name, "_release"}, 32'(bus_if.READY), 32'd0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    vec_t       vecs[$];
    dec_t       decs[$];
    logic [3:0] dout;
    logic       doe;
    logic       seen;

    initial begin
        bus_if.AS20 = 1'b1;
        bus_if.DS20 = 1'b1;
        bus_if.RW20 = 1'b1;
        bus_if.A    = 24'hE80000;
        bus_if.D    = 4'h0;

        vecs.push_back('{1'b1, 24'hE80000, 4'h0, 4'hC});
        vecs.push_back('{1'b1, 24'hE80002, 4'h0, 4'h1});
        vecs.push_back('{1'b1, 24'hE80004, 4'h0, 4'h8});
        vecs.push_back('{1'b1, 24'hE80006, 4'h0, 4'hD});
        vecs.push_back('{1'b1, 24'hE80008, 4'h0, 4'hF});
        vecs.push_back('{1'b1, 24'hE8000C, 4'h0, 4'hF});
        vecs.push_back('{1'b1, 24'hE80010, 4'h0, 4'hF});
        vecs.push_back('{1'b1, 24'hE80012, 4'h0, 4'h8});
        vecs.push_back('{1'b1, 24'hE80014, 4'h0, 4'h2});
        vecs.push_back('{1'b1, 24'hE80016, 4'h0, 4'h4});
        vecs.push_back('{1'b1, 24'hE80018, 4'h0, 4'hE});
        vecs.push_back('{1'b1, 24'hE8001A, 4'h0, 4'hD});
        vecs.push_back('{1'b1, 24'hE80024, 4'h0, 4'h8});
        vecs.push_back('{1'b1, 24'hE80026, 4'h0, 4'h7});
        vecs.push_back('{1'b1, 24'hE80028, 4'h0, 4'hF});
        vecs.push_back('{1'b1, 24'hE80040, 4'h0, 4'hF});
        vecs.push_back('{1'b0, 24'hE8004A, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 24'hE80048, 4'h2, 4'h0});
        vecs.push_back('{1'b1, 24'hE80000, 4'h0, 4'hE});
        vecs.push_back('{1'b1, 24'hE80002, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 24'hE80004, 4'h0, 4'h8});
        vecs.push_back('{1'b1, 24'hE80006, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 24'hE8004A, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 24'hE80048, 4'h2, 4'h0});
        vecs.push_back('{1'b1, 24'hE80000, 4'h0, 4'hE});
        vecs.push_back('{1'b1, 24'hE80002, 4'h0, 4'h6});
        vecs.push_back('{1'b0, 24'hE8004C, 4'h0, 4'h0});

        decs.push_back('{24'h200000, 3'b100});
        decs.push_back('{24'h210000, 3'b101});
        decs.push_back('{24'h3F0000, 3'b101});
        decs.push_back('{24'h000000, 3'b101});
        decs.push_back('{24'hA00000, 3'b111});
        decs.push_back('{24'h200000, 3'b100});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();

        check("rst_dout",       32'(bus_if.DOUT),   32'hF);
        check("rst_doe",        32'(bus_if.DOE),    32'd0);
        check("rst_ready",      32'(bus_if.READY),  32'd0);
        check("rst_configured", 32'(configured),    32'd0);
        check("rst_decode",     32'(decode),        32'h7);
        check("rst_access",     32'(bus_if.ACCESS), 32'd0);

        // Exact READY timing on a read of $00.
        @(negedge clk);
        bus_if.RW20 = 1'b1;
        bus_if.A    = 24'hE80000;
        bus_if.AS20 = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.DS20 = 1'b0;
        tick();
        tick();
        check("t_ready_e", 32'(bus_if.READY), 32'd0);
        tick();
        check("t_ready_e1", 32'(bus_if.READY), 32'd1);
        check("t_doe_e1",   32'(bus_if.DOE),   32'd1);
        check("t_dout_e1",  32'(bus_if.DOUT),  32'hC);
        @(negedge clk);
        bus_if.AS20 = 1'b1;
        bus_if.DS20 = 1'b1;
        tick();
        tick();
        check("t_ready_hold", 32'(bus_if.READY), 32'd1);
        tick();
        check("t_ready_fall", 32'(bus_if.READY), 32'd0);
        check("t_doe_fall",   32'(bus_if.DOE),   32'd0);
        repeat (2) tick();

        foreach (vecs[i]) begin
            do_cycle($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, dout, doe);
            if (vecs[i].rw) begin
                check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp));
                check($sformatf("vec%0d_doe", i),  32'(doe),  32'd1);
            end else begin
                check($sformatf("vec%0d_doe", i),  32'(doe),  32'd0);
            end
        end

        check("chain_configured", 32'(configured), 32'h3);
        @(negedge clk);
        bus_if.A = 24'hE80000;
        #1;
        check("chain_done_access", 32'(bus_if.ACCESS), 32'd1);

        foreach (decs[i]) begin
            @(negedge clk);
            bus_if.A = decs[i].addr;
            tick();
            tick();
            check($sformatf("dec%0d", i), 32'(decode), 32'(decs[i].exp_dec));
        end

        // AS pulse with no DS: nothing happens.
        do_reset();
        @(negedge clk);
        bus_if.A    = 24'hE80048;
        bus_if.RW20 = 1'b0;
        bus_if.D    = 4'h2;
        bus_if.AS20 = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); seen |= bus_if.READY; end
        @(negedge clk);
        bus_if.AS20 = 1'b1;
        repeat (6) begin tick(); seen |= bus_if.READY; end
        check("abort_ready",      32'(seen),       32'd0);
        check("abort_configured", 32'(configured), 32'd0);
        check("abort_state",      32'(dbg_state),  32'(ST_IDLE));

        // DS pulse while AS is high is ignored.
        @(negedge clk);
        bus_if.DS20 = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); seen |= bus_if.READY; end
        @(negedge clk);
        bus_if.DS20 = 1'b1;
        repeat (4) tick();
        check("ds_only_ready", 32'(seen), 32'd0);

        // Reset between DS falling and the commit.
        do_cycle("pre_lo", 1'b0, 24'hE8004A, 4'h0, dout, doe);
        @(negedge clk);
        bus_if.A    = 24'hE80048;
        bus_if.RW20 = 1'b0;
        bus_if.D    = 4'h2;
        bus_if.AS20 = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.DS20 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_configured", 32'(configured),   32'd0);
        check("mid_rst_ready",      32'(bus_if.READY), 32'd0);
        check("mid_rst_doe",        32'(bus_if.DOE),   32'd0);
        check("mid_rst_dout",       32'(bus_if.DOUT),  32'hF);
        check("mid_rst_decode",     32'(decode),       32'h7);
        seen = 1'b0;
        repeat (8) begin tick(); seen |= bus_if.READY; end
        check("mid_rst_no_resp", 32'(seen),      32'd0);
        check("mid_rst_state",   32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        bus_if.AS20 = 1'b1;
        bus_if.DS20 = 1'b1;
        repeat (4) tick();
        check("mid_rst_after", 32'(configured), 32'd0);

        // Exact commit timing of a $48 write, then the 64K window.
        do_cycle("cfg_lo", 1'b0, 24'hE8004A, 4'h0, dout, doe);
        @(negedge clk);
        bus_if.A    = 24'hE80048;
        bus_if.RW20 = 1'b0;
        bus_if.D    = 4'h2;
        bus_if.AS20 = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.DS20 = 1'b0;
        tick();
        tick();
        check("cfg_e",  32'(configured), 32'd0);
        tick();
        check("cfg_e1", 32'(configured), 32'd1);
        @(negedge clk);
        bus_if.AS20 = 1'b1;
        bus_if.DS20 = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        bus_if.A = 24'h200000;
        tick();
        tick();
        check("cfg_dec_hit", 32'(decode[0]), 32'd0);
        @(negedge clk);
        bus_if.A = 24'h210000;
        tick();
        tick();
        check("cfg_dec_miss", 32'(decode[0]), 32'd1);
        @(negedge clk);
        bus_if.A = 24'hE90000;
        #1;
        check("access_e9", 32'(bus_if.ACCESS), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
